// File: rtl/aes_pkg.sv
// Shared definitions for the two-channel AES round scheduler: FSM state
// encoding, block/round constants and the channel id type.
package aes_pkg;

  // AES-128: ten core invocations per block, 128-bit blocks, 4-bit round index.
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_DATA_W     = 128;
  localparam int AES_RW         = 4;

  // Scheduler states. WAIT waits for the core, NEXT issues the following round,
  // OUT holds the ciphertext until the downstream path accepts it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_NEXT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Channel id carried with every block (two requesters).
  typedef logic chan_t;

  localparam chan_t CHAN0 = 1'b0;
  localparam chan_t CHAN1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational; the priority
// pointer moves to the other channel only when the grant is actually taken.
module rr_arbiter2
  import aes_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  req0,
  input  logic  req1,
  input  logic  enable,
  input  logic  accept,
  output logic  grant_valid,
  output chan_t grant_chan
);

  chan_t rr_ptr_reg;

  // Pick the lone requester, or the pointer's channel when both are asking.
  always_comb begin
    grant_chan = CHAN0;
    if (req0 && req1) begin
      grant_chan = rr_ptr_reg;
    end else if (req1) begin
      grant_chan = CHAN1;
    end
    grant_valid = enable & (req0 | req1);
  end

  // After a taken grant the other channel gets priority next time.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr_reg <= CHAN0;
    end else if (accept && grant_valid) begin
      rr_ptr_reg <= ~grant_chan;
    end
  end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one AES round core between two plaintext requesters. Blocks are
// granted round-robin, run through NUM_ROUNDS core invocations and returned
// on a single output path tagged with the originating channel.
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int DATA_W     = AES_DATA_W,
  parameter int RW         = AES_RW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              core_enable,
  output logic [DATA_W-1:0] core_i_text,
  output logic [RW-1:0]     core_round,
  input  logic [DATA_W-1:0] core_o_text,
  input  logic [DATA_W-1:0] core_rkey,
  input  logic              core_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_chan,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

  state_t            state_reg, state_next;
  logic [RW-1:0]     round_reg, round_next;
  logic [DATA_W-1:0] text_reg, text_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  chan_t             chan_reg, chan_next;

  logic              grant_valid;
  logic              grant_take;
  chan_t             grant_chan;
  logic              arb_enable;
  logic [DATA_W-1:0] grant_data;
  logic [1:0]        ready_vec;

  // Arbitration only happens in IDLE and never while reset is asserted,
  // so a reset cycle can never pop a FIFO.
  assign arb_enable = (state_reg == ST_IDLE) && resetn;

  rr_arbiter2 u_arb (
    .clock       (clock),
    .resetn      (resetn),
    .req0        (req0_valid),
    .req1        (req1_valid),
    .enable      (arb_enable),
    .accept      (grant_take),
    .grant_valid (grant_valid),
    .grant_chan  (grant_chan)
  );

  assign grant_data = (grant_chan == CHAN1) ? req1_data : req0_data;

  // One pop strobe per channel; at most one of them is high because there
  // is a single grant.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = grant_take && ((gi == 1) ? grant_chan : ~grant_chan);
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign core_round = round_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign out_data   = out_data_reg;
  assign out_chan   = chan_reg;

  // Scheduler next-state and strobe generation.
  always_comb begin
    state_next    = state_reg;
    round_next    = round_reg;
    text_next     = text_reg;
    chan_next     = chan_reg;
    out_data_next = out_data_reg;
    core_enable   = 1'b0;
    core_i_text   = text_reg;
    grant_take    = 1'b0;
    out_valid     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        round_next = '0;
        if (grant_valid) begin
          // Initial AddRoundKey is folded into the first core issue.
          grant_take  = 1'b1;
          core_enable = 1'b1;
          core_i_text = grant_data ^ core_rkey;
          text_next   = grant_data ^ core_rkey;
          chan_next   = grant_chan;
          state_next  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (core_done) begin
          if (round_reg == LAST_ROUND) begin
            out_data_next = core_o_text;
            state_next    = ST_OUT;
          end else begin
            round_next = round_reg + RW'(1);
            state_next = ST_NEXT;
          end
        end
      end

      ST_NEXT: begin
        // Feed the previous round's result straight back into the core.
        core_enable = 1'b1;
        core_i_text = core_o_text;
        text_next   = core_o_text;
        state_next  = ST_WAIT;
      end

      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          round_next = '0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        round_next = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      round_reg    <= '0;
      text_reg     <= '0;
      chan_reg     <= CHAN0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      round_reg    <= round_next;
      text_reg     <= text_next;
      chan_reg     <= chan_next;
      out_data_reg <= out_data_next;
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: an AES-128 round-core model with selectable
// done delay, two requester FIFO models and an output scoreboard.
module tb_aes_round_scheduler;
  import aes_pkg::*;

  localparam int NR = AES_NUM_ROUNDS;

  logic         clock;
  logic         resetn;
  logic         req0_valid, req1_valid;
  logic [127:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         core_enable;
  logic [127:0] core_i_text;
  logic [3:0]   core_round;
  logic [127:0] core_o_text = '0;
  logic [127:0] core_rkey;
  logic         core_done;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_chan;
  logic         out_ready;
  logic         busy;

  aes_round_scheduler dut (
    .clock       (clock),
    .resetn      (resetn),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .core_enable (core_enable),
    .core_i_text (core_i_text),
    .core_round  (core_round),
    .core_o_text (core_o_text),
    .core_rkey   (core_rkey),
    .core_done   (core_done),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- AES-128 reference ----------------
  logic [127:0] rk [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv = 8'h01;
    logic [7:0] b = v;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, b);
      b = gmul(b, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] din, input int r);
    logic [7:0]   st [16];
    logic [7:0]   sh [16];
    logic [7:0]   mx [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i] = sbox(din[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) sh[w+4*c] = st[w+4*((c+w)%4)];
    for (int c = 0; c < 4; c++) begin
      if (r != 10) begin
        mx[4*c]   = gmul(sh[4*c], 8'h02) ^ gmul(sh[4*c+1], 8'h03) ^ sh[4*c+2] ^ sh[4*c+3];
        mx[4*c+1] = sh[4*c] ^ gmul(sh[4*c+1], 8'h02) ^ gmul(sh[4*c+2], 8'h03) ^ sh[4*c+3];
        mx[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ gmul(sh[4*c+2], 8'h02) ^ gmul(sh[4*c+3], 8'h03);
        mx[4*c+3] = gmul(sh[4*c], 8'h03) ^ sh[4*c+1] ^ sh[4*c+2] ^ gmul(sh[4*c+3], 8'h02);
      end else begin
        for (int w = 0; w < 4; w++) mx[4*c+w] = sh[4*c+w];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = mx[i];
    return res ^ rk[r];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, r);
    return s;
  endfunction

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // ---------------- Round core model ----------------
  logic         var_delay = 1'b0;
  logic         stray_done = 1'b0;
  logic         done_q = 1'b0;
  int           core_cnt = 0;
  logic [127:0] core_res = '0;
  logic [127:0] key0 = '0;

  assign core_rkey = key0;
  assign core_done = done_q | stray_done;

  // Each enable launches one AES round; done pulses after 1..7 cycles.
  always @(posedge clock) begin
    done_q <= 1'b0;
    if (!resetn) begin
      core_cnt <= 0;
    end else if (core_enable) begin
      core_cnt <= var_delay ? int'($urandom_range(7, 1)) : 1;
      core_res <= aes_round(core_i_text, int'(core_round) + 1);
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        done_q      <= 1'b1;
        core_o_text <= core_res;
      end
    end
  end

  // ---------------- Scoreboard and bookkeeping ----------------
  typedef struct {
    logic         chan;
    logic [127:0] data;
  } exp_t;

  exp_t         sb_q [$];
  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  int           n_assert = 0;
  int           n_fail = 0;
  int           en_cnt = 0;
  int           pops0 = 0, pops1 = 0;
  int           exp_pops0 = 0, exp_pops1 = 0;
  logic         prev_en = 1'b0;
  logic         s_r0 = 1'b0, s_r1 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update_req();
    req0_valid = (q0.size() != 0);
    req0_data  = req0_valid ? q0[0] : '0;
    req1_valid = (q1.size() != 0);
    req1_data  = req1_valid ? q1[0] : '0;
  endtask

  task automatic push_exp(input logic ch, input logic [127:0] pt, input logic [127:0] ct);
    exp_t e;
    e.chan = ch;
    e.data = ct;
    sb_q.push_back(e);
    if (ch) begin
      q1.push_back(pt);
      exp_pops1++;
    end else begin
      q0.push_back(pt);
      exp_pops0++;
    end
    update_req();
  endtask

  task automatic push(input logic ch, input logic [127:0] pt);
    push_exp(ch, pt, aes_enc(pt));
  endtask

  task automatic accept_out();
    exp_t e;
    chk("output_expected", 128'(sb_q.size() != 0), 128'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      $display("txn out chan=%0d data=%h enables=%0d", out_chan, out_data, en_cnt);
      chk("out_chan", 128'(out_chan), 128'(e.chan));
      chk("out_data", out_data, e.data);
      chk("enables_per_block", 128'(en_cnt), 128'(NR));
    end
    en_cnt = 0;
  endtask

  // One clock: observe at the falling edge, then apply FIFO pops after the rise.
  task automatic step();
    @(negedge clock);
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    chk("single_pop", 128'(s_r0 & s_r1), 128'(0));
    chk("pop_outside_idle", 128'((s_r0 | s_r1) & busy), 128'(0));
    chk("enable_back_to_back", 128'(core_enable & prev_en), 128'(0));
    prev_en = core_enable;
    if (core_enable) en_cnt++;
    if (s_r0) pops0++;
    if (s_r1) pops1++;
    if (out_valid && out_ready) accept_out();
    @(posedge clock);
    #1;
    if (s_r0 && q0.size() != 0) q0.delete(0);
    if (s_r1 && q1.size() != 0) q1.delete(0);
    update_req();
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int i = 0;
    while ((sb_q.size() != 0 || busy || q0.size() != 0 || q1.size() != 0) && i < max_cyc) begin
      step();
      i++;
    end
    chk({tag, "_drained"}, 128'(i < max_cyc), 128'(1));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    en_cnt = 0;
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    logic [127:0] exp_s;
    logic         stable;
    int           en_snap, pop_snap, i;

    resetn     = 1'b0;
    out_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    key_expand(128'h000102030405060708090a0b0c0d0e0f);
    key0 = rk[0];
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;

    // Reset state: every output low.
    chk("reset_strobes", 128'({req0_ready, req1_ready, core_enable, core_round,
                               out_valid, out_chan, busy}), 128'(0));
    chk("reset_core_i_text", core_i_text, '0);
    chk("reset_out_data", out_data, '0);

    // FIPS-197 known-answer block on channel 0.
    push_exp(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_drain("fips", 500);
    chk("fips_pops_ch0", 128'(pops0), 128'(1));
    chk("fips_pops_ch1", 128'(pops1), 128'(0));

    // Both channels loaded from reset: grants alternate 0,1,0,1.
    do_reset();
    push(1'b0, 128'h0123456789abcdef0011223344556677);
    push(1'b1, 128'hfedcba98765432108899aabbccddeeff);
    push(1'b0, 128'h00000000000000000000000000000000);
    push(1'b1, 128'hffffffffffffffffffffffffffffffff);
    wait_drain("fairness", 1000);

    // Output backpressure: hold for 50 cycles with no pops or core activity.
    out_ready = 1'b0;
    push(1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    exp_s = aes_enc(128'h3243f6a8885a308d313198a2e0370734);
    i = 0;
    while (!out_valid && i < 500) begin
      step();
      i++;
    end
    chk("hold_reached_out", 128'(out_valid), 128'(1));
    en_snap  = en_cnt;
    pop_snap = pops0 + pops1;
    push(1'b0, 128'h11111111111111111111111111111111);
    stable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (out_data !== exp_s || out_chan !== 1'b1 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("hold_output_stable", 128'(stable), 128'(1));
    chk("hold_no_enable", 128'(en_cnt), 128'(en_snap));
    chk("hold_no_pop", 128'(pops0 + pops1), 128'(pop_snap));
    out_ready = 1'b1;
    step();
    chk("hold_accept_idle", 128'(busy), 128'(0));
    wait_drain("hold", 500);

    // Reset during WAIT of round 5 drops the block; rr_ptr returns to 0.
    push(1'b0, 128'hdeadbeefdeadbeefdeadbeefdeadbeef);
    i = 0;
    while (!(busy && !core_enable && core_round == 4'd5) && i < 500) begin
      step();
      i++;
    end
    chk("reached_round5_wait", 128'(core_round), 128'(5));
    sb_q.delete();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    en_cnt = 0;
    chk("midreset_strobes", 128'({req0_ready, req1_ready, core_enable, core_round,
                                  out_valid, out_chan, busy}), 128'(0));
    chk("midreset_out_data", out_data, '0);
    chk("midreset_core_i_text", core_i_text, '0);
    push(1'b0, 128'h0f0e0d0c0b0a09080706050403020100);
    push(1'b1, 128'hcafebabecafebabecafebabecafebabe);
    wait_drain("after_reset", 1000);

    // Only channel 1 requests while rr_ptr points at 0: granted immediately.
    do_reset();
    push(1'b1, 128'h55555555555555555555555555555555);
    step();
    chk("req1_immediate_grant", 128'(s_r1), 128'(1));
    wait_drain("req1_only", 500);
    push(1'b0, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
    push(1'b1, 128'h123456789abcdef0123456789abcdef0);
    wait_drain("req1_then_both", 1000);

    // Variable core latency and a stray core_done while idle.
    var_delay = 1'b1;
    push(1'b0, 128'h00112233445566778899aabbccddeeff);
    push(1'b1, 128'h13579bdf02468ace13579bdf02468ace);
    push(1'b0, 128'h8899aabbccddeeff0011223344556677);
    wait_drain("var_delay", 3000);
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    chk("stray_done_ignored", 128'({busy, core_enable, out_valid}), 128'(0));
    step();
    push(1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_drain("after_stray", 1000);

    chk("total_pops_ch0", 128'(pops0), 128'(exp_pops0));
    chk("total_pops_ch1", 128'(pops1), 128'(exp_pops1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
